// File: rtl/cfe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfe_pkg : shared widths, feedback FSM states and saturating add     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cfe_pkg;

  localparam int CFE_NBW_FO   = 13;
  localparam int CFE_NBI_FO   = -2;
  localparam int CFE_NBW_LAT  = 32;
  localparam int CFE_NBW_CORR = 16;
  localparam int CFE_NBW_DROP = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } cfe_fb_state_t;

  // Sum is formed one bit wider than the operands so the clamp sees the true value.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = $signed({a[31], a}) + $signed({b[31], b});
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfe_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfe_wait_counter : loadable down-counter with zero flag             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cfe_wait_counter
  import cfe_pkg::*;
#(
  parameter int W = cfe_pkg::CFE_NBW_LAT
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cfe_fo_feedback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfe_fo_feedback_ctrl : forwards FO estimates, accumulates correction |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cfe_fo_feedback_ctrl
  import cfe_pkg::*;
#(
  parameter int CFE_NBW_FO   = cfe_pkg::CFE_NBW_FO,
  parameter int CFE_NBW_LAT  = cfe_pkg::CFE_NBW_LAT,
  parameter int CFE_NBW_CORR = cfe_pkg::CFE_NBW_CORR,
  parameter int CFE_NBW_DROP = cfe_pkg::CFE_NBW_DROP
) (
  input  logic                    clk,
  input  logic                    rst_async,
  input  logic                    i_clear,
  input  logic                    i_est_valid,
  input  logic [CFE_NBW_FO-1:0]   i_est_fo,
  input  logic [CFE_NBW_LAT-1:0]  i_wait,
  output logic                    o_valid,
  output logic [CFE_NBW_FO-1:0]   o_fo_value,
  output logic [CFE_NBW_CORR-1:0] o_fo_corr,
  output logic                    o_busy,
  output logic [CFE_NBW_DROP-1:0] o_drop_cnt
);

  cfe_fb_state_t          state_q;
  logic                    valid_q;
  logic                    busy_q;
  logic [CFE_NBW_FO-1:0]   fo_q;
  logic [CFE_NBW_CORR-1:0] corr_q;
  logic [CFE_NBW_CORR-1:0] corr_d;
  logic [CFE_NBW_DROP-1:0] drop_q;
  logic [CFE_NBW_DROP-1:0] drop_d;
  logic                    w_cnt_zero;

  logic signed [31:0] w_corr_ext;
  logic signed [31:0] w_fo_neg;
  logic signed [31:0] w_sat;
  logic               w_sat_unused;

  // Negation in 32 bits keeps the most-negative estimate exact ahead of the clamp.
  assign w_corr_ext   = {{(32-CFE_NBW_CORR){corr_q[CFE_NBW_CORR-1]}}, corr_q};
  assign w_fo_neg     = -{{(32-CFE_NBW_FO){fo_q[CFE_NBW_FO-1]}}, fo_q};
  assign w_sat        = sat_add(w_corr_ext, w_fo_neg, CFE_NBW_CORR);
  assign corr_d       = w_sat[CFE_NBW_CORR-1:0];
  assign w_sat_unused = ^w_sat[31:CFE_NBW_CORR];

  assign drop_d = (drop_q == '1) ? drop_q : drop_q + CFE_NBW_DROP'(1);

  cfe_wait_counter #(
    .W (CFE_NBW_LAT)
  ) u_wait_counter (
    .clk        (clk),
    .rst_async  (rst_async),
    .i_clear    (i_clear),
    .i_load     (state_q == ST_LOAD),
    .i_load_val (i_wait),
    .i_dec      (state_q == ST_WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fo_q    <= '0;
      corr_q  <= '0;
      drop_q  <= '0;
    end else if (i_clear) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      corr_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (i_est_valid && (state_q != ST_IDLE)) begin
        drop_q <= drop_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_est_valid) begin
            state_q <= ST_FWD;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            fo_q    <= i_est_fo;
          end
        end
        ST_FWD: begin
          corr_q  <= corr_d;
          valid_q <= 1'b0;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_cnt_zero) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_fo_value = fo_q;
  assign o_fo_corr  = corr_q;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_cfe_fo_feedback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cfe_fo_feedback_ctrl : self-checking bench with timeline model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cfe_fo_feedback_ctrl;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        i_clear;
  logic        i_est_valid;
  logic [12:0] i_est_fo;
  logic [31:0] i_wait;
  logic        o_valid;
  logic [12:0] o_fo_value;
  logic [15:0] o_fo_corr;
  logic        o_busy;
  logic [15:0] o_drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_k counts cycles since acceptance (0 = idle); busy spans k = 1 .. N+3.
  longint m_k;
  longint m_n;
  int     m_fo;
  int     m_corr;
  int     m_drop;

  cfe_fo_feedback_ctrl dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .i_clear     (i_clear),
    .i_est_valid (i_est_valid),
    .i_est_fo    (i_est_fo),
    .i_wait      (i_wait),
    .o_valid     (o_valid),
    .o_fo_value  (o_fo_value),
    .o_fo_corr   (o_fo_corr),
    .o_busy      (o_busy),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_k = 0; m_n = 0; m_fo = 0; m_corr = 0; m_drop = 0;
  endtask

  task automatic drive_cycle(input logic v, input logic [12:0] fo, input logic [31:0] w,
                             input logic clr);
    i_est_valid = v; i_est_fo = fo; i_wait = w; i_clear = clr;
    @(posedge clk);
    if (clr) begin
      m_k = 0; m_corr = 0; m_drop = 0;
    end else begin
      if (v && m_k != 0 && m_drop < 65535) m_drop++;
      if (m_k == 0) begin
        if (v) begin
          m_k  = 1;
          m_fo = int'($signed(fo));
        end
      end else if (m_k == 1) begin
        m_corr = m_corr - m_fo;
        if (m_corr > 32767) m_corr = 32767;
        if (m_corr < -32768) m_corr = -32768;
        m_k = 2;
      end else if (m_k == 2) begin
        m_n = longint'(w);
        m_k = 3;
      end else if (m_k == m_n + 3) begin
        m_k = 0;
      end else begin
        m_k++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_async = 1'b1; i_clear = 1'b0; i_est_valid = 1'b0; i_est_fo = '0; i_wait = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
    n_checks++; if (o_fo_value !== 13'h0) begin n_errors++; $display("FAIL reset_fo: got %0h expected 0", o_fo_value); end
    n_checks++; if (o_fo_corr !== 16'h0) begin n_errors++; $display("FAIL reset_corr: got %0h expected 0", o_fo_corr); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
    n_checks++; if (o_drop_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_drop: got %0h expected 0", o_drop_cnt); end
    rst_async = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int busy_cnt;
    int guard;
    drive_cycle(1'b0, 13'h0, 32'd4, 1'b0);
    drive_cycle(1'b1, 13'h020, 32'd4, 1'b0);
    n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid_t1: got %0b expected 1", o_valid); end
    n_checks++; if (o_fo_value !== 13'h020) begin n_errors++; $display("FAIL single_fo_t1: got %0h expected 020", o_fo_value); end
    busy_cnt = o_busy ? 1 : 0;
    drive_cycle(1'b0, 13'h0, 32'd4, 1'b0);
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_t2: got %0b expected 0", o_valid); end
    n_checks++; if (o_fo_corr !== 16'hFFE0) begin n_errors++; $display("FAIL single_corr_t2: got %0h expected ffe0", o_fo_corr); end
    guard = 0;
    while (o_busy && guard < 50) begin
      busy_cnt++;
      drive_cycle(1'b0, 13'h0, 32'd4, 1'b0);
      guard++;
    end
    n_checks++; if (busy_cnt != 7) begin n_errors++; $display("FAIL single_busy_len: got %0d expected 7", busy_cnt); end
    drive_cycle(1'b1, 13'h020, 32'd4, 1'b0);
    n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL single_reaccept: got %0b expected 1", o_valid); end
    guard = 0;
    while (o_busy && guard < 50) begin
      drive_cycle(1'b0, 13'h0, 32'd4, 1'b0);
      guard++;
    end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL single_settle: got busy %0b expected 0", o_busy); end
    n_checks++; if (o_fo_corr !== 16'hFFC0) begin n_errors++; $display("FAIL single_corr_2nd: got %0h expected ffc0", o_fo_corr); end
  endtask

  task automatic test_back_to_back();
    int fwd;
    int guard;
    drive_cycle(1'b0, 13'h0, 32'd2, 1'b1);
    fwd = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 13'h020, 32'd2, 1'b0);
      if (o_valid) fwd++;
      n_checks++;
      if (o_valid !== (m_k == 1)) begin
        n_errors++; $display("FAIL b2b_fwd_time cycle %0d: got %0b expected %0b", i, o_valid, (m_k == 1));
      end
    end
    guard = 0;
    while (o_busy && guard < 20) begin
      drive_cycle(1'b0, 13'h0, 32'd2, 1'b0);
      guard++;
    end
    n_checks++; if (fwd != 4) begin n_errors++; $display("FAIL b2b_fwd_count: got %0d expected 4", fwd); end
    n_checks++; if (o_drop_cnt !== 16'd16) begin n_errors++; $display("FAIL b2b_drop: got %0d expected 16", o_drop_cnt); end
    n_checks++; if (o_fo_corr !== 16'hFF80) begin n_errors++; $display("FAIL b2b_corr: got %0h expected ff80", o_fo_corr); end
  endtask

  task automatic test_saturation();
    logic [15:0] e_corr;
    int prev;
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b1);
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 13'h1000, 32'd0, 1'b0);
      e_corr = 16'(m_corr);
      n_checks++;
      if (o_fo_corr !== e_corr || int'($signed(o_fo_corr)) < prev) begin
        n_errors++; $display("FAIL sat_pos cycle %0d: got %0h expected %0h", i, o_fo_corr, e_corr);
      end
      prev = int'($signed(o_fo_corr));
    end
    n_checks++; if (o_fo_corr !== 16'h7FFF) begin n_errors++; $display("FAIL sat_pos_final: got %0h expected 7fff", o_fo_corr); end
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b1);
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 13'h0FFF, 32'd0, 1'b0);
      e_corr = 16'(m_corr);
      n_checks++;
      if (o_fo_corr !== e_corr) begin
        n_errors++; $display("FAIL sat_neg cycle %0d: got %0h expected %0h", i, o_fo_corr, e_corr);
      end
    end
    n_checks++; if (o_fo_corr !== 16'h8000) begin n_errors++; $display("FAIL sat_neg_final: got %0h expected 8000", o_fo_corr); end
  endtask

  task automatic test_wait_extremes();
    int busy_cnt;
    int guard;
    logic stayed_busy;
    logic [15:0] e_drop;
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b1);
    drive_cycle(1'b1, 13'h0, 32'd0, 1'b0);
    busy_cnt = 0; guard = 0;
    while (o_busy && guard < 20) begin
      busy_cnt++;
      drive_cycle(1'b0, 13'h0, 32'd0, 1'b0);
      guard++;
    end
    n_checks++; if (busy_cnt != 3) begin n_errors++; $display("FAIL wait0_busy_len: got %0d expected 3", busy_cnt); end
    drive_cycle(1'b1, 13'h011, 32'hFFFF_FFFF, 1'b0);
    drive_cycle(1'b0, 13'h0, 32'hFFFF_FFFF, 1'b0);
    drive_cycle(1'b0, 13'h0, 32'hFFFF_FFFF, 1'b0);
    stayed_busy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom_range(0, 7) == 0), 13'h0, 32'd0, 1'b0);
      if (!o_busy) stayed_busy = 1'b0;
    end
    n_checks++; if (stayed_busy !== 1'b1) begin n_errors++; $display("FAIL waitmax_early_exit: got busy dropout expected continuous busy"); end
    e_drop = 16'(m_drop);
    n_checks++; if (o_drop_cnt !== e_drop) begin n_errors++; $display("FAIL waitmax_drop: got %0d expected %0d", o_drop_cnt, e_drop); end
    #2;
    rst_async = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_fo_corr !== 16'h0 || o_drop_cnt !== 16'h0 || o_fo_value !== 13'h0) begin
      n_errors++;
      $display("FAIL async_reset: got valid=%0b busy=%0b corr=%0h drop=%0h fo=%0h expected all 0",
               o_valid, o_busy, o_fo_corr, o_drop_cnt, o_fo_value);
    end
    @(posedge clk);
    #2;
    rst_async = 1'b0;
    model_reset();
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b0);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy: got %0b expected 0", o_busy); end
  endtask

  task automatic test_clear();
    drive_cycle(1'b1, 13'h055, 32'd10, 1'b0);
    drive_cycle(1'b1, 13'h033, 32'd10, 1'b0);
    drive_cycle(1'b1, 13'h033, 32'd10, 1'b0);
    drive_cycle(1'b1, 13'h033, 32'd10, 1'b0);
    n_checks++; if (o_busy !== 1'b1 || o_drop_cnt !== 16'd3 || o_fo_corr !== 16'hFFAB) begin
      n_errors++; $display("FAIL clear_setup: got busy=%0b drop=%0d corr=%0h expected 1/3/ffab", o_busy, o_drop_cnt, o_fo_corr);
    end
    drive_cycle(1'b1, 13'h0AA, 32'd10, 1'b1);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL clear_busy: got %0b expected 0", o_busy); end
    n_checks++; if (o_fo_corr !== 16'h0) begin n_errors++; $display("FAIL clear_corr: got %0h expected 0", o_fo_corr); end
    n_checks++; if (o_drop_cnt !== 16'h0) begin n_errors++; $display("FAIL clear_drop: got %0h expected 0", o_drop_cnt); end
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL clear_valid: got %0b expected 0", o_valid); end
    drive_cycle(1'b0, 13'h0, 32'd10, 1'b0);
    n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL clear_no_fwd: got valid=%0b busy=%0b expected 0/0", o_valid, o_busy);
    end
    n_checks++; if (o_fo_value !== 13'h055) begin n_errors++; $display("FAIL clear_fo_hold: got %0h expected 055", o_fo_value); end
  endtask

  // Bench stands in for cfe_wait_feedback: o_wait grows 0x100 per forward, capped at 0x1000.
  task automatic test_feedback_loop();
    logic [31:0] fb_wait;
    longint      cyc;
    longint      last;
    longint      exp_gap;
    int          fwds;
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b1);
    fb_wait = 32'd0; cyc = 0; last = 0; exp_gap = 0; fwds = 0;
    while (fwds < 18 && cyc < 60000) begin
      drive_cycle(1'b1, 13'h080, fb_wait, 1'b0);
      cyc++;
      if (o_valid) begin
        if (fwds > 0) begin
          n_checks++;
          if (cyc - last != exp_gap) begin
            n_errors++; $display("FAIL fb_spacing fwd %0d: got %0d expected %0d", fwds, cyc - last, exp_gap);
          end
        end
        fb_wait = (fb_wait + 32'h100 > 32'h1000) ? 32'h1000 : fb_wait + 32'h100;
        exp_gap = longint'(fb_wait) + 4;
        last = cyc;
        fwds++;
      end
    end
    n_checks++; if (fwds != 18) begin n_errors++; $display("FAIL fb_fwd_count: got %0d expected 18", fwds); end
    drive_cycle(1'b0, 13'h0, fb_wait, 1'b0);
    n_checks++; if (o_fo_corr !== 16'hF700) begin n_errors++; $display("FAIL fb_corr: got %0h expected f700", o_fo_corr); end
  endtask

  task automatic test_random();
    logic        v;
    logic        clr;
    logic [12:0] fo;
    logic [31:0] w;
    drive_cycle(1'b0, 13'h0, 32'd0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 59) == 0);
      fo  = 13'($urandom);
      w   = 32'($urandom_range(0, 5));
      drive_cycle(v, fo, w, clr);
      n_checks++;
      if (o_valid !== (m_k == 1) || o_busy !== (m_k != 0) || o_fo_value !== 13'(m_fo) ||
          o_fo_corr !== 16'(m_corr) || o_drop_cnt !== 16'(m_drop)) begin
        n_errors++;
        $display("FAIL random cycle %0d: got v=%0b b=%0b fo=%0h corr=%0h drop=%0h expected v=%0b b=%0b fo=%0h corr=%0h drop=%0h",
                 i, o_valid, o_busy, o_fo_value, o_fo_corr, o_drop_cnt,
                 (m_k == 1), (m_k != 0), 13'(m_fo), 16'(m_corr), 16'(m_drop));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_wait_extremes();
    test_clear();
    test_feedback_loop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
